// File: rtl/issueint_exec.sv
// Integer execution unit: takes one instruction from the issue queue, computes it and holds the
// result on the common data bus until granted. Define ISSUEINT_EXEC_MUL_EN for a multi-cycle MUL.
module issueint_exec #(
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  issueint_opcode,
    input  logic [5:0]  issueint_rdtag,
    input  logic [31:0] issueint_rsdata,
    input  logic [31:0] issueint_rtdata,
    input  logic        issueint_ready,
    output logic        issueint_done,
    output logic        cdb_req,
    input  logic        cdb_grant,
    output logic [5:0]  cdb_tag,
    output logic [31:0] cdb_data,
    output logic        cdb_valid
);

    localparam logic [5:0] OpSll = 6'h00;
    localparam logic [5:0] OpSrl = 6'h02;
    localparam logic [5:0] OpAdd = 6'h20;
    localparam logic [5:0] OpSub = 6'h22;
    localparam logic [5:0] OpAnd = 6'h24;
    localparam logic [5:0] OpOr  = 6'h25;
    localparam logic [5:0] OpXor = 6'h26;
    localparam logic [5:0] OpNor = 6'h27;
    localparam logic [5:0] OpSlt = 6'h2A;

    if (MUL_LATENCY < 2 || MUL_LATENCY > 15) begin : g_bad_latency
        $error("MUL_LATENCY must be within 2..15");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StResult} state_e;

    state_e      state_q, state_d;
    logic [5:0]  tag_q, tag_d;
    logic [31:0] data_q, data_d;
    logic [31:0] alu_res;
    logic        accept;

`ifdef ISSUEINT_EXEC_MUL_EN
    localparam logic [5:0] OpMul = 6'h18;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mul_lo;
    logic        is_mul;

    // Low half of a two's-complement product does not depend on operand signedness.
    assign mul_lo = issueint_rsdata * issueint_rtdata;
    assign is_mul = (issueint_opcode == OpMul);
`endif

    assign accept = issueint_ready & ~reset &
                    ((state_q == StIdle) | ((state_q == StResult) & cdb_grant));

    assign issueint_done = accept;
    assign cdb_req       = (state_q == StResult) & ~reset;
    assign cdb_valid     = cdb_req & cdb_grant;
    assign cdb_tag       = tag_q;
    assign cdb_data      = data_q;

    always_comb begin
        alu_res = 32'h0;
        case (issueint_opcode)
            OpAdd: alu_res = issueint_rsdata + issueint_rtdata;
            OpSub: alu_res = issueint_rsdata - issueint_rtdata;
            OpAnd: alu_res = issueint_rsdata & issueint_rtdata;
            OpOr:  alu_res = issueint_rsdata | issueint_rtdata;
            OpXor: alu_res = issueint_rsdata ^ issueint_rtdata;
            OpNor: alu_res = ~(issueint_rsdata | issueint_rtdata);
            OpSlt: alu_res = ($signed(issueint_rsdata) < $signed(issueint_rtdata)) ? 32'h1 : 32'h0;
            OpSll: alu_res = issueint_rtdata << issueint_rsdata[4:0];
            OpSrl: alu_res = issueint_rtdata >> issueint_rsdata[4:0];
`ifdef ISSUEINT_EXEC_MUL_EN
            OpMul: alu_res = mul_lo;
`endif
            default: alu_res = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        data_d  = data_q;
`ifdef ISSUEINT_EXEC_MUL_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            StResult: begin
                if (cdb_grant && !issueint_ready) state_d = StIdle;
            end
`ifdef ISSUEINT_EXEC_MUL_EN
            StBusy: begin
                // Result becomes visible on the edge where the counter reaches zero.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = StResult;
                end
            end
`endif
            default: ;
        endcase
        if (accept) begin
            tag_d   = issueint_rdtag;
            data_d  = alu_res;
            state_d = StResult;
`ifdef ISSUEINT_EXEC_MUL_EN
            if (is_mul) begin
                state_d = StBusy;
                cnt_d   = 4'(MUL_LATENCY - 1);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            tag_q   <= 6'h0;
            data_q  <= 32'h0;
`ifdef ISSUEINT_EXEC_MUL_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
`ifdef ISSUEINT_EXEC_MUL_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_issueint_exec.sv
// Self-checking bench for issueint_exec: inline checks per scenario plus a CDB scoreboard.
module tb_issueint_exec;

    localparam int unsigned MulLat = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  issueint_opcode = 6'h0;
    logic [5:0]  issueint_rdtag = 6'h0;
    logic [31:0] issueint_rsdata = 32'h0;
    logic [31:0] issueint_rtdata = 32'h0;
    logic        issueint_ready = 1'b0;
    logic        issueint_done;
    logic        cdb_req;
    logic        cdb_grant = 1'b0;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_valid;

    int total = 0;
    int bad = 0;
    logic [37:0] exp_q[$];

    issueint_exec #(.MUL_LATENCY(MulLat)) dut (
        .clk(clk),
        .reset(reset),
        .issueint_opcode(issueint_opcode),
        .issueint_rdtag(issueint_rdtag),
        .issueint_rsdata(issueint_rsdata),
        .issueint_rtdata(issueint_rtdata),
        .issueint_ready(issueint_ready),
        .issueint_done(issueint_done),
        .cdb_req(cdb_req),
        .cdb_grant(cdb_grant),
        .cdb_tag(cdb_tag),
        .cdb_data(cdb_data),
        .cdb_valid(cdb_valid)
    );

    always #5 clk = ~clk;

    // Scoreboard: every bus publication must match the oldest expected result.
    always @(negedge clk) begin
        if (cdb_valid !== 1'b0) begin
            logic [37:0] e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL cdb_pub: got tag=%h data=%h valid=%b, required no publication",
                         cdb_tag, cdb_data, cdb_valid);
            end else begin
                e = exp_q.pop_front();
                if ({cdb_tag, cdb_data} !== e) begin
                    bad++;
                    $display("FAIL cdb_pub: got tag=%h data=%h, required tag=%h data=%h",
                             cdb_tag, cdb_data, e[37:32], e[31:0]);
                end
            end
        end
    end

    function automatic logic [31:0] exp_alu(input logic [5:0] op, input logic [31:0] rs,
                                            input logic [31:0] rt);
        logic [4:0] sh;
        sh = rs[4:0];
        case (op)
            6'h20: return rs + rt;
            6'h22: return rs - rt;
            6'h24: return rs & rt;
            6'h25: return rs | rt;
            6'h26: return rs ^ rt;
            6'h27: return ~(rs | rt);
            6'h2A: return ($signed(rs) < $signed(rt)) ? 32'h1 : 32'h0;
            6'h00: return rt << sh;
            6'h02: return rt >> sh;
            default: return 32'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [5:0] op, input logic [5:0] tag, input logic [31:0] rs,
                         input logic [31:0] rt);
        issueint_opcode = op;
        issueint_rdtag  = tag;
        issueint_rsdata = rs;
        issueint_rtdata = rt;
        issueint_ready  = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cdb_grant = 1'b1;
        offer(6'h20, 6'h1, 32'h1, 32'h1);
        @(negedge clk);
        total++;
        if ({issueint_done, cdb_req, cdb_valid} !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs: got done/req/valid=%b, required 000",
                     {issueint_done, cdb_req, cdb_valid});
        end
        tick();
        issueint_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({cdb_req, cdb_tag, cdb_data} !== 39'h0) begin
            bad++;
            $display("FAIL reset_state: got req=%b tag=%h data=%h, required 0 0 0",
                     cdb_req, cdb_tag, cdb_data);
        end
        tick();
    endtask

    task automatic test_add();
        cdb_grant = 1'b1;
        offer(6'h20, 6'd3, 32'd5, 32'd7);
        exp_q.push_back({6'd3, 32'd12});
        @(negedge clk);
        total++;
        if (issueint_done !== 1'b1) begin
            bad++;
            $display("FAIL add_done: got %b, required 1", issueint_done);
        end
        tick();
        issueint_ready = 1'b0;
        @(negedge clk);
        total++;
        if (cdb_valid !== 1'b1) begin
            bad++;
            $display("FAIL add_valid: got %b, required 1", cdb_valid);
        end
        tick();
        @(negedge clk);
        total++;
        if (cdb_req !== 1'b0) begin
            bad++;
            $display("FAIL add_idle: got req=%b, required 0", cdb_req);
        end
    endtask

    task automatic test_hold();
        tick();
        cdb_grant = 1'b0;
        offer(6'h22, 6'd4, 32'd0, 32'd1);
        exp_q.push_back({6'd4, 32'hFFFF_FFFF});
        tick();
        offer(6'h20, 6'd6, 32'd1, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({cdb_req, issueint_done, cdb_valid, cdb_tag, cdb_data} !==
                {3'b100, 6'd4, 32'hFFFF_FFFF}) begin
                bad++;
                $display("FAIL hold_%0d: got req/done/valid=%b tag=%h data=%h, required 100 04 ffffffff",
                         i, {cdb_req, issueint_done, cdb_valid}, cdb_tag, cdb_data);
            end
            tick();
        end
        cdb_grant = 1'b1;
        exp_q.push_back({6'd6, 32'd2});
        @(negedge clk);
        total++;
        if ({issueint_done, cdb_valid} !== 2'b11) begin
            bad++;
            $display("FAIL hold_release: got done/valid=%b, required 11",
                     {issueint_done, cdb_valid});
        end
        tick();
        issueint_ready = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        cdb_grant = 1'b1;
        offer(6'h2A, 6'd10, 32'hFFFF_FFFF, 32'd1);
        exp_q.push_back({6'd10, 32'd1});
        @(negedge clk);
        total++;
        if ({issueint_done, cdb_valid} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_first: got done/valid=%b, required 10", {issueint_done, cdb_valid});
        end
        tick();
        offer(6'h00, 6'd11, 32'd4, 32'd1);
        exp_q.push_back({6'd11, 32'd16});
        @(negedge clk);
        total++;
        if ({issueint_done, cdb_valid} !== 2'b11) begin
            bad++;
            $display("FAIL b2b_sll: got done/valid=%b, required 11", {issueint_done, cdb_valid});
        end
        tick();
        offer(6'h02, 6'd12, 32'd31, 32'h8000_0000);
        exp_q.push_back({6'd12, 32'd1});
        @(negedge clk);
        total++;
        if ({issueint_done, cdb_valid} !== 2'b11) begin
            bad++;
            $display("FAIL b2b_srl: got done/valid=%b, required 11", {issueint_done, cdb_valid});
        end
        tick();
        issueint_ready = 1'b0;
        @(negedge clk);
        total++;
        if (cdb_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_last: got valid=%b, required 1", cdb_valid);
        end
        tick();
    endtask

    task automatic test_random();
        logic [5:0] ops[10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02,
                                6'h3F};
        logic [5:0]  op;
        logic [31:0] rs, rt;
        cdb_grant = 1'b1;
        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 9)];
            rs = $urandom;
            rt = $urandom;
            offer(op, 6'(i), rs, rt);
            exp_q.push_back({6'(i), exp_alu(op, rs, rt)});
            @(negedge clk);
            total++;
            if (issueint_done !== 1'b1) begin
                bad++;
                $display("FAIL rand_done_%0d: got %b, required 1", i, issueint_done);
            end
            tick();
        end
        issueint_ready = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        cdb_grant = 1'b1;
        offer(6'h18, 6'd9, 32'hFFFF_FFFD, 32'd4);
`ifdef ISSUEINT_EXEC_MUL_EN
        exp_q.push_back({6'd9, 32'hFFFF_FFF4});
        @(negedge clk);
        total++;
        if (issueint_done !== 1'b1) begin
            bad++;
            $display("FAIL mul_accept: got %b, required 1", issueint_done);
        end
        tick();
        offer(6'h20, 6'd13, 32'd2, 32'd3);
        for (int i = 1; i < int'(MulLat); i++) begin
            @(negedge clk);
            total++;
            if ({issueint_done, cdb_req} !== 2'b00) begin
                bad++;
                $display("FAIL mul_busy_%0d: got done/req=%b, required 00", i,
                         {issueint_done, cdb_req});
            end
            tick();
        end
        exp_q.push_back({6'd13, 32'd5});
        @(negedge clk);
        total++;
        if ({issueint_done, cdb_valid} !== 2'b11) begin
            bad++;
            $display("FAIL mul_result: got done/valid=%b, required 11", {issueint_done, cdb_valid});
        end
        tick();
        issueint_ready = 1'b0;
        tick();
`else
        exp_q.push_back({6'd9, 32'h0});
        @(negedge clk);
        total++;
        if (issueint_done !== 1'b1) begin
            bad++;
            $display("FAIL mul_accept: got %b, required 1", issueint_done);
        end
        tick();
        issueint_ready = 1'b0;
        @(negedge clk);
        total++;
        if (cdb_valid !== 1'b1) begin
            bad++;
            $display("FAIL mul_nomacro: got valid=%b, required 1", cdb_valid);
        end
        tick();
`endif
    endtask

    task automatic test_reset_result();
        cdb_grant = 1'b0;
        offer(6'h20, 6'd5, 32'd1, 32'd1);
        tick();
        issueint_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({cdb_req, cdb_tag} !== {1'b1, 6'd5}) begin
            bad++;
            $display("FAIL rst_hold: got req=%b tag=%h, required 1 05", cdb_req, cdb_tag);
        end
        tick();
        reset = 1'b1;
        cdb_grant = 1'b1;
        @(negedge clk);
        total++;
        if ({cdb_req, cdb_valid} !== 2'b00) begin
            bad++;
            $display("FAIL rst_during: got req/valid=%b, required 00", {cdb_req, cdb_valid});
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({cdb_req, cdb_tag, cdb_data} !== 39'h0) begin
            bad++;
            $display("FAIL rst_after: got req=%b tag=%h data=%h, required 0 0 0",
                     cdb_req, cdb_tag, cdb_data);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_hold();
        test_back_to_back();
        test_random();
        test_mul();
        test_reset_result();
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issueint_exec.md
ISSUEINT_EXEC -- requirements
Module: issueint_exec

Interface
REQ-001 Parameter: MUL_LATENCY, default 4, cycles from MUL acceptance to result held; legal range 2..15.
REQ-002 clk  input  1  sole clock, all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 issueint_opcode  input  6  opcode of the offered instruction.
REQ-005 issueint_rdtag  input  6  destination tag of the offered instruction.
REQ-006 issueint_rsdata  input  32  operand rs.
REQ-007 issueint_rtdata  input  32  operand rt.
REQ-008 issueint_ready  input  1  queue offers a valid instruction this cycle.
REQ-009 issueint_done  output  1  instruction accepted this cycle; queue retires it at the same edge.
REQ-010 cdb_req  output  1  result held, requesting the common data bus.
REQ-011 cdb_grant  input  1  arbiter grants the bus this cycle.
REQ-012 cdb_tag  output  6  tag of the held result.
REQ-013 cdb_data  output  32  held result value.
REQ-014 cdb_valid  output  1  result is published on the bus this cycle.

Function
REQ-015 The block SHALL implement states IDLE (nothing held), BUSY (multiply in progress), RESULT (result held, cdb_req=1).
REQ-016 issueint_done SHALL equal issueint_ready & ~reset & (state==IDLE | (state==RESULT & cdb_grant)), combinationally.
REQ-017 cdb_valid SHALL equal cdb_req & cdb_grant; cdb_tag/cdb_data SHALL come directly from the result registers.
REQ-018 Operations (result registered at acceptance edge): 6'h20 ADD rs+rt, 6'h22 SUB rs-rt, 6'h24 AND, 6'h25 OR, 6'h26 XOR, 6'h27 NOR, 6'h2A SLT (signed rs<rt ? 1 : 0), 6'h00 SLL rt<<rs[4:0], 6'h02 SRL rt>>rs[4:0] (logical); all arithmetic modulo 2^32, no overflow trap.
REQ-019 Any other opcode SHALL produce result 32'h0 with its rdtag, single-cycle.
REQ-020 Non-MUL acceptance SHALL move to RESULT at the next edge; cdb_req asserted the cycle after acceptance (latency 1).
REQ-021 In RESULT with cdb_grant=0 the held tag/data SHALL stay stable and cdb_req stay high indefinitely.
REQ-022 In RESULT with cdb_grant=1 and issueint_ready=1 the new instruction SHALL be accepted in the same cycle (back-to-back, one result per cycle).
REQ-023 In RESULT with cdb_grant=1 and issueint_ready=0 the block SHALL return to IDLE, cdb_req=0 next cycle.
REQ-024 cdb_grant while cdb_req=0 SHALL be ignored (cdb_valid=0).
REQ-025 In BUSY issueint_done SHALL be 0 and cdb_req 0; a 4-bit counter loaded with MUL_LATENCY-1 decrements each cycle; at 0 the state moves to RESULT.

Reset
REQ-026 With reset high at a clock edge: state=IDLE, counter=0, cdb_tag=6'h0, cdb_data=32'h0; cdb_req=0, cdb_valid=0, issueint_done=0 during reset cycles.
REQ-027 Reset asserted in BUSY or RESULT SHALL discard the in-flight instruction without a CDB publication.

Configuration
REQ-028 Macro ISSUEINT_EXEC_MUL_EN defined: opcode 6'h18 MUL (low 32 bits of signed rs*rt) SHALL enter BUSY and produce the result MUL_LATENCY cycles after acceptance (cdb_req asserted MUL_LATENCY cycles after acceptance cycle).
REQ-029 Macro undefined: no multiplier or BUSY logic synthesized; 6'h18 SHALL follow REQ-019.

Verification
REQ-030 Reset, then ADD rs=5 rt=7 rdtag=3, grant held high -> done=1 same cycle; next cycle cdb_valid=1, tag=3, data=12.
REQ-031 SUB rs=0 rt=1 with grant=0 for 5 cycles -> cdb_req high, data=32'hFFFFFFFF stable, done=0 while ready=1; grant=1 -> cdb_valid=1 and next instruction accepted same cycle.
REQ-032 Continuous ready and grant, SLT(-1,1), SLL(rs=4,rt=1), SRL(rs=31,rt=32'h80000000) -> one publication per cycle: 1, 16, 1.
REQ-033 With ISSUEINT_EXEC_MUL_EN, MUL rs=-3 rt=4 tag=9 -> done=0 for MUL_LATENCY-1 cycles, then cdb_valid with data=32'hFFFFFFF4 tag=9; without macro -> data=0 one cycle after acceptance.
REQ-034 Reset asserted while RESULT holds tag=5 with grant=0 -> next cycle cdb_req=0, cdb_tag=0, cdb_data=0, no cdb_valid pulse.
